regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the ALU and the load/memory unit.
- Arbitrates the two sources and registers the selected write, which drives the register file's write, rd and reg_write inputs.
- Holds a pending-write scoreboard and produces the decode-stage stall signal for RAW and WAW hazards.

Parameters:
- XLEN, 32, data width of writeback and register file.
- RR_EN, 1, 1 = round-robin between sources; 0 = fixed priority, mem always wins.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset; 0 = reset asserted.
- alu_valid  input  1  ALU writeback request.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- alu_ready  output  1  ALU request granted this cycle.
- mem_valid  input  1  load writeback request.
- mem_rd  input  5  load destination register.
- mem_data  input  XLEN  load data.
- mem_ready  output  1  load request granted this cycle.
- issue_valid  input  1  decode issuing an instruction.
- issue_rd  input  5  destination of issuing instruction (0 = no writeback).
- issue_rs1  input  5  source 1 of issuing instruction.
- issue_rs2  input  5  source 2 of issuing instruction.
- issue_stall  output  1  issuing instruction must hold.
- rf_write  output  1  register file write enable (registered).
- rf_rd  output  5  register file destination (registered).
- rf_wdata  output  XLEN  register file write data (registered).
- busy  output  32  pending-write scoreboard, bit n = xn has an outstanding write.

Behaviour:
- Reset (rst=0, async): rf_write=0, rf_rd=0, rf_wdata=0, busy=0, last_grant=mem (so ALU wins the first tie); ready outputs are combinational and forced 0 while in reset.
- Handshake: a transfer occurs when valid && ready in the same cycle.
  - A source holds valid, rd and data stable until it is granted.
  - Ready never depends on ready; at most one of alu_ready and mem_ready is 1 per cycle.
- Arbitration, combinational within the cycle:
  - Only one source valid: it is granted.
  - Both valid, RR_EN=1: the source not granted last is granted; last_grant updates on every transfer.
  - Both valid, RR_EN=0: mem is granted.
- Output stage:
  - On a transfer with rd!=0, at the next rising edge: rf_write=1, rf_rd=rd, rf_wdata=data.
  - Otherwise rf_write=0 at the next edge; rf_rd and rf_wdata hold their previous values.
  - Transfer with rd=0 completes the handshake, but rf_write stays 0.
  - Latency: grant cycle N, rf_write=1 in cycle N+1, register file updated at end of N+1.
  - Sustained throughput: one write per cycle.
- Scoreboard update at each rising edge:
  - Clear: if rf_write=1, busy[rf_rd] is cleared; this is the same edge at which the register file commits.
  - Set: issue accepted (issue_valid=1, issue_stall=0, issue_rd!=0) sets busy[issue_rd].
  - Set and clear on the same register in the same edge: set wins.
  - busy[0] is always 0.
- Stall (combinational): issue_stall = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]).
  - The busy[issue_rd] term is the WAW check.
  - Register 0 never stalls.
  - Stall is computed from the registered busy vector only; there is no same-cycle bypass of rf_write. The reader proceeds the cycle after the clear.
- Reset mid-operation: an in-flight registered write is dropped (rf_write forced 0); the scoreboard is cleared; pending handshakes are abandoned.

Test Plan:
- Reset: rst=0 mid-cycle with alu_valid=1 -> immediately rf_write=0, busy=0, alu_ready=0; after release, alu_ready=1 in the first cycle.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF in cycle N -> alu_ready=1 in N; rf_write=1, rf_rd=5, rf_wdata=0xDEADBEEF in N+1; rf_write=0 in N+2.
- Contention, RR_EN=1: both valid for 4 cycles, alu_rd=1, mem_rd=2 -> grants ALU, mem, ALU, mem; rf_rd sequence 1, 2, 1, 2.
- Contention, RR_EN=0: both valid for 3 cycles -> mem_ready=1 every cycle; alu_ready=0 throughout.
- RAW hazard: issue_rd=7 accepted (busy[7]=1); next cycle issue_rs1=7 -> issue_stall=1 until ALU writes x7; stall drops the cycle after rf_write=1 with rf_rd=7.
- x0 and set/clear race:
  - alu_rd=0 transfer -> alu_ready=1, rf_write stays 0.
  - rf_write=1 with rf_rd=3 in the same cycle that an issue with issue_rd=3 is accepted -> busy[3]=1 after the edge.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file writeback arbiter with pending-write scoreboard
// Arbitrates ALU and load writebacks onto one registered write port and raises the decode stall.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  output logic            issue_stall,
  output logic            rf_write,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  src_e            last_grant_q, last_grant_d;
  logic            rf_write_q, rf_write_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]     busy_q, busy_d;

  logic alu_win;
  logic mem_win;
  logic issue_accept;

  // On a tie, round-robin favours whichever source did not win last time.
  always_comb begin
    alu_win = 1'b0;
    mem_win = 1'b0;
    if (alu_valid && mem_valid) begin
      if (RR_EN && (last_grant_q == SRC_MEM)) begin
        alu_win = 1'b1;
      end else begin
        mem_win = 1'b1;
      end
    end else begin
      alu_win = alu_valid;
      mem_win = mem_valid;
    end
    alu_ready = alu_win && rst;
    mem_ready = mem_win && rst;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rf_write_d   = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    if (alu_ready) begin
      last_grant_d = SRC_ALU;
      if (alu_rd != 5'd0) begin
        rf_write_d = 1'b1;
        rf_rd_d    = alu_rd;
        rf_wdata_d = alu_data;
      end
    end else if (mem_ready) begin
      last_grant_d = SRC_MEM;
      if (mem_rd != 5'd0) begin
        rf_write_d = 1'b1;
        rf_rd_d    = mem_rd;
        rf_wdata_d = mem_data;
      end
    end
  end

  // Stall looks only at the registered scoreboard, so a reader waits one cycle past the commit.
  assign issue_stall  = issue_valid &&
                        (busy_q[issue_rs1] || busy_q[issue_rs2] || busy_q[issue_rd]);
  assign issue_accept = issue_valid && !issue_stall && (issue_rd != 5'd0);

  always_comb begin
    busy_d = busy_q;
    if (rf_write_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (issue_accept) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= SRC_MEM;
      rf_write_q   <= 1'b0;
      rf_rd_q      <= 5'd0;
      rf_wdata_q   <= '0;
      busy_q       <= 32'd0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_write_q   <= rf_write_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_write = rf_write_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule
